hazard_sequencer: RTL and testbench
===================================

Name: hazard_sequencer

Overview:
- Pipeline sequencing block for the 5-stage MIPS core.
- Tracks in-flight destination registers in an EX/MEM/WB scoreboard and detects RAW and load-use hazards against the instruction in ID.
- Drives `bubble` into the pipelined control decoder, and drives the PC / IF-ID register enables and the IF-ID flush.
- Sequences the taken-branch squash window and keeps a saturating count of stall cycles.

Parameters:
- FORWARDING, 1: 1 = forwarding present, so only load-use stalls; 0 = stall on any match in EX or MEM.
- BRANCH_PENALTY, 2: cycles of squash after a taken branch resolved in EX (range 1..3).
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  5  source register rs of the ID instruction
- id_rt  in  5  source register rt of the ID instruction
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- id_dst  in  5  destination after the RegDst mux
- id_regwrite  in  1  ID instruction writes the register file
- id_memread  in  1  ID instruction is a load
- id_jump  in  1  ID instruction is J
- ex_branch_taken  in  1  BEQ in EX resolved taken
- bubble  out  1  to control decoder: zero ID/EX controls
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  clear IF/ID to NOP
- stall_cycles  out  CNT_W  saturating count of load-use/RAW stall cycles

Behaviour:
- Reset: asynchronous, active-high. Clears scoreboard valids, state=RUN, flush_cnt=0, stall_cycles=0.
- While rst=1: bubble=1, pc_write=0, ifid_write=0, ifid_flush=0.
- Scoreboard: three slots EX, MEM, WB, each {valid, dst, regwrite, memread}.
  - Every clock: WB<=MEM, MEM<=EX.
  - EX<=ID fields if issue, else EX<=invalid.
  - issue = id_valid & !hazard & state==RUN & !ex_branch_taken.
- Match(slot) = slot.valid & slot.regwrite & slot.dst!=0 & ((id_uses_rs & id_rs==slot.dst) | (id_uses_rt & id_rt==slot.dst)).
- hazard:
  - FORWARDING=1: Match(EX) & EX.memread.
  - FORWARDING=0: Match(EX) | Match(MEM).
  - WB is never a hazard (the register file writes before it reads).
  - hazard is qualified by id_valid.
- Outputs are combinational from state, scoreboard and inputs; no added latency.
- FSM states: RUN, FLUSH.
- RUN, priority order:
  1. ex_branch_taken: pc_write=1 (target), ifid_flush=1, bubble=1, ifid_write=1; go to FLUSH with flush_cnt=BRANCH_PENALTY-1. If BRANCH_PENALTY=1, stay in RUN.
  2. hazard: bubble=1, pc_write=0, ifid_write=0, ifid_flush=0; stall_cycles+=1, saturating at all-ones.
  3. id_valid & id_jump: pc_write=1, ifid_write=1, ifid_flush=1, bubble=0 (jump itself proceeds).
  4. else: pc_write=1, ifid_write=1, bubble=0, ifid_flush=0.
- FLUSH:
  - Outputs: bubble=1, ifid_flush=1, pc_write=1, ifid_write=1.
  - ex_branch_taken, hazard and id_jump are ignored.
  - flush_cnt decrements; at 0, return to RUN next cycle.
- Simultaneous events:
  - Branch taken with hazard: branch wins, no stall counted, and the ID instruction is not recorded.
  - Hazard with jump: stall; the jump is re-evaluated next cycle.
- Register 0 never matches.
- The counter does not wrap.
- Reset asserted mid-FLUSH or mid-stall aborts immediately to reset values.

Decomposition:
- Shared package `mips_pipe_pkg` holds:
  - the state enum {RUN, FLUSH};
  - the scoreboard entry struct sb_entry_t {valid, dst[4:0], regwrite, memread};
  - constant REG_ZERO=5'd0.
- One sub-module, `hazard_scoreboard`: the 3-slot shift register plus its Match logic, with outputs match_ex, match_mem and ex_is_load.
- The FSM and counter stay in the top.

Test Plan:
- Load-use: issue LW dst=8, then ID ADD rs=8 → exactly 1 cycle of bubble=1, pc_write=0, ifid_write=0; stall_cycles=1; ADD issues next cycle.
- RAW without load (FORWARDING=1): ADD dst=9, then ID uses rt=9 → no stall. With FORWARDING=0 → 2 stall cycles (match in EX, then MEM); stall_cycles=2.
- Taken branch, BRANCH_PENALTY=2: pulse ex_branch_taken → ifid_flush=1 and bubble=1 for 2 consecutive cycles; the flushed ID instruction's dst is never present in the scoreboard.
- Branch taken in the same cycle as a load-use hazard → flush behaviour, stall_cycles unchanged; J in ID → single-cycle ifid_flush with bubble=0.
- Dst=0 load followed by a use of r0 → no stall. Force stall_cycles to 16'hFFFE, then 3 stalls → counter holds 16'hFFFF.
- Assert rst during FLUSH → outputs go to reset values asynchronously; after release, state=RUN and an immediate rs-match on a stale entry produces no stall.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared types for the 5-stage MIPS pipeline control blocks:
// sequencer state, in-flight scoreboard entry and the register-match helper.
package mips_pipe_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } seq_state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic       regwrite;
    logic       memread;
  } sb_entry_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, dst: 5'd0, regwrite: 1'b0, memread: 1'b0};

  // r0 is hard-wired, so a pending write to it can never create a dependency
  function automatic logic slot_match(
    input sb_entry_t  e,
    input logic       uses_rs,
    input logic [4:0] rs,
    input logic       uses_rt,
    input logic [4:0] rt
  );
    return e.valid & e.regwrite & (e.dst != REG_ZERO) &
           ((uses_rs & (rs == e.dst)) | (uses_rt & (rt == e.dst)));
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-slot EX/MEM/WB record of in-flight destination registers and the
// source-register match against the instruction currently in ID.
module hazard_scoreboard
  import mips_pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       issue,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic [4:0] id_dst,
  input  logic       id_regwrite,
  input  logic       id_memread,
  output logic       match_ex,
  output logic       match_mem,
  output logic       ex_is_load
);

  localparam int SLOT_EX  = 0;
  localparam int SLOT_MEM = 1;
  localparam int SLOT_WB  = 2;

  sb_entry_t slot_r [0:2];
  sb_entry_t ex_next_s;

  // entry entering EX: the ID instruction when it issues, otherwise a bubble
  always_comb begin
    ex_next_s = SB_EMPTY;
    if (issue) begin
      ex_next_s = '{valid: 1'b1, dst: id_dst, regwrite: id_regwrite, memread: id_memread};
    end else begin
      ex_next_s = SB_EMPTY;
    end
  end

  // shift the pipeline record down one stage every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_r[SLOT_EX]  <= SB_EMPTY;
      slot_r[SLOT_MEM] <= SB_EMPTY;
      slot_r[SLOT_WB]  <= SB_EMPTY;
    end else begin
      slot_r[SLOT_WB]  <= slot_r[SLOT_MEM];
      slot_r[SLOT_MEM] <= slot_r[SLOT_EX];
      slot_r[SLOT_EX]  <= ex_next_s;
    end
  end

  assign match_ex   = slot_match(slot_r[SLOT_EX], id_uses_rs, id_rs, id_uses_rt, id_rt);
  assign match_mem  = slot_match(slot_r[SLOT_MEM], id_uses_rs, id_rs, id_uses_rt, id_rt);
  assign ex_is_load = slot_r[SLOT_EX].valid & slot_r[SLOT_EX].memread;

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline sequencer: stalls on RAW/load-use hazards, squashes fetch after a
// taken branch or jump, and counts stall cycles (saturating).
module hazard_sequencer
  import mips_pipe_pkg::*;
#(
  parameter int FORWARDING     = 1,
  parameter int BRANCH_PENALTY = 2,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       id_dst,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_jump,
  input  logic             ex_branch_taken,
  output logic             bubble,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [1:0] FLUSH_INIT = 2'(BRANCH_PENALTY - 1);

  seq_state_t       state_r, state_n;
  logic [1:0]       flush_cnt_r, flush_cnt_n;
  logic [CNT_W-1:0] stall_r;

  logic match_ex_s, match_mem_s, ex_is_load_s;
  logic hazard_s, issue_s, stall_inc_s;
  logic bubble_s, pc_write_s, ifid_write_s, ifid_flush_s;

  hazard_scoreboard u_sb (
    .clk         (clk),
    .rst         (rst),
    .issue       (issue_s),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .id_dst      (id_dst),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .match_ex    (match_ex_s),
    .match_mem   (match_mem_s),
    .ex_is_load  (ex_is_load_s)
  );

  // with forwarding only a load in EX cannot be bypassed in time
  assign hazard_s = id_valid & ((FORWARDING != 0) ? (match_ex_s & ex_is_load_s)
                                                  : (match_ex_s | match_mem_s));
  assign issue_s  = id_valid & ~hazard_s & (state_r == RUN) & ~ex_branch_taken;

  // next-state and pipeline control decode
  always_comb begin
    state_n      = state_r;
    flush_cnt_n  = flush_cnt_r;
    bubble_s     = 1'b1;
    pc_write_s   = 1'b0;
    ifid_write_s = 1'b0;
    ifid_flush_s = 1'b0;
    stall_inc_s  = 1'b0;
    case (state_r)
      RUN: begin
        if (ex_branch_taken) begin
          pc_write_s   = 1'b1;
          ifid_write_s = 1'b1;
          ifid_flush_s = 1'b1;
          if (BRANCH_PENALTY > 1) begin
            state_n     = FLUSH;
            flush_cnt_n = FLUSH_INIT;
          end else begin
            state_n     = RUN;
            flush_cnt_n = 2'd0;
          end
        end else if (hazard_s) begin
          stall_inc_s = 1'b1;
        end else if (id_valid & id_jump) begin
          bubble_s     = 1'b0;
          pc_write_s   = 1'b1;
          ifid_write_s = 1'b1;
          ifid_flush_s = 1'b1;
        end else begin
          bubble_s     = 1'b0;
          pc_write_s   = 1'b1;
          ifid_write_s = 1'b1;
        end
      end
      FLUSH: begin
        pc_write_s   = 1'b1;
        ifid_write_s = 1'b1;
        ifid_flush_s = 1'b1;
        if (flush_cnt_r <= 2'd1) begin
          state_n     = RUN;
          flush_cnt_n = 2'd0;
        end else begin
          flush_cnt_n = flush_cnt_r - 2'd1;
        end
      end
      default: begin
        state_n     = RUN;
        flush_cnt_n = 2'd0;
      end
    endcase
  end

  // sequencer state and flush window counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= RUN;
      flush_cnt_r <= 2'd0;
    end else begin
      state_r     <= state_n;
      flush_cnt_r <= flush_cnt_n;
    end
  end

  // stall-cycle counter, holds at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_r <= {CNT_W{1'b0}};
    end else if (stall_inc_s && (stall_r != {CNT_W{1'b1}})) begin
      stall_r <= stall_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_r <= stall_r;
    end
  end

  // reset forces a safe freeze regardless of the decode
  assign bubble       = rst | bubble_s;
  assign pc_write     = ~rst & pc_write_s;
  assign ifid_write   = ~rst & ifid_write_s;
  assign ifid_flush   = ~rst & ifid_flush_s;
  assign stall_cycles = stall_r;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Table-driven bench for hazard_sequencer: one forwarding instance (penalty 2)
// and one non-forwarding instance (penalty 1, 2-bit counter to reach saturation).
module tb_hazard_sequencer;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] dst;
    logic       rw;
    logic       mr;
    logic       j;
    logic       br;
  } in_t;

  typedef struct packed {
    logic        bubble;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic [15:0] stall;
  } exp_t;

  typedef struct {
    in_t   i;
    exp_t  e;
    string nm;
  } vec_t;

  typedef struct {
    logic  sel_b;
    exp_t  e;
    string nm;
  } pend_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  in_t  a = '0;
  in_t  b = '0;

  logic       a_bub, a_pc, a_iw, a_fl;
  logic [15:0] a_st;
  logic       b_bub, b_pc, b_iw, b_fl;
  logic [1:0] b_st;

  int total = 0;
  int passed = 0;
  pend_t pq[$];

  always #5 clk = ~clk;

  hazard_sequencer #(.FORWARDING(1), .BRANCH_PENALTY(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .id_valid(a.v), .id_rs(a.rs), .id_rt(a.rt),
    .id_uses_rs(a.urs), .id_uses_rt(a.urt), .id_dst(a.dst), .id_regwrite(a.rw),
    .id_memread(a.mr), .id_jump(a.j), .ex_branch_taken(a.br),
    .bubble(a_bub), .pc_write(a_pc), .ifid_write(a_iw), .ifid_flush(a_fl),
    .stall_cycles(a_st)
  );

  hazard_sequencer #(.FORWARDING(0), .BRANCH_PENALTY(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .id_valid(b.v), .id_rs(b.rs), .id_rt(b.rt),
    .id_uses_rs(b.urs), .id_uses_rt(b.urt), .id_dst(b.dst), .id_regwrite(b.rw),
    .id_memread(b.mr), .id_jump(b.j), .ex_branch_taken(b.br),
    .bubble(b_bub), .pc_write(b_pc), .ifid_write(b_iw), .ifid_flush(b_fl),
    .stall_cycles(b_st)
  );

  function automatic in_t mi(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                             input logic urs, input logic urt, input logic [4:0] dst,
                             input logic rw, input logic mr, input logic j, input logic br);
    mi = '{v: v, rs: rs, rt: rt, urs: urs, urt: urt, dst: dst, rw: rw, mr: mr, j: j, br: br};
  endfunction

  function automatic exp_t me(input logic bb, input logic pc, input logic iw,
                              input logic fl, input logic [15:0] st);
    me = '{bubble: bb, pc_write: pc, ifid_write: iw, ifid_flush: fl, stall: st};
  endfunction

  task automatic push(input logic sel_b, input exp_t e, input string nm);
    pend_t p;
    p.sel_b = sel_b;
    p.e = e;
    p.nm = nm;
    pq.push_back(p);
  endtask

  task automatic pop_check();
    pend_t p;
    exp_t  got;
    p = pq.pop_front();
    if (p.sel_b) got = me(b_bub, b_pc, b_iw, b_fl, 16'(b_st));
    else         got = me(a_bub, a_pc, a_iw, a_fl, a_st);
    total++;
    if (got === p.e) passed++;
    else $display("FAIL %s: got bub/pc/iw/fl=%b%b%b%b stall=%h, expected %b%b%b%b stall=%h",
                  p.nm, got.bubble, got.pc_write, got.ifid_write, got.ifid_flush, got.stall,
                  p.e.bubble, p.e.pc_write, p.e.ifid_write, p.e.ifid_flush, p.e.stall);
  endtask

  task automatic run_vec(input logic sel_b, input in_t v, input exp_t e, input string nm);
    @(posedge clk);
    #1;
    if (sel_b) b = v;
    else       a = v;
    push(sel_b, e, nm);
    @(negedge clk);
    pop_check();
  endtask

  vec_t tva[17];
  vec_t tvb[10];
  in_t  idle;

  initial begin
    idle = mi(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // forwarding instance: load-use, r0, branch/flush, jump cases
    tva[0]  = '{mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),    me(0, 1, 1, 0, 16'd0), "a_idle"};
    tva[1]  = '{mi(1, 1, 0, 1, 0, 8, 1, 1, 0, 0),    me(0, 1, 1, 0, 16'd0), "a_lw8"};
    tva[2]  = '{mi(1, 8, 2, 1, 1, 10, 1, 0, 0, 0),   me(1, 0, 0, 0, 16'd0), "a_loaduse_stall"};
    tva[3]  = '{mi(1, 8, 2, 1, 1, 10, 1, 0, 0, 0),   me(0, 1, 1, 0, 16'd1), "a_loaduse_issue"};
    tva[4]  = '{mi(1, 0, 10, 0, 1, 11, 1, 0, 0, 0),  me(0, 1, 1, 0, 16'd1), "a_raw_fwd_nostall"};
    tva[5]  = '{mi(1, 3, 0, 1, 0, 0, 1, 1, 0, 0),    me(0, 1, 1, 0, 16'd1), "a_lw_r0"};
    tva[6]  = '{mi(1, 0, 0, 1, 1, 12, 1, 0, 0, 0),   me(0, 1, 1, 0, 16'd1), "a_use_r0"};
    tva[7]  = '{mi(1, 4, 0, 1, 0, 13, 1, 1, 0, 0),   me(0, 1, 1, 0, 16'd1), "a_lw13"};
    tva[8]  = '{mi(1, 13, 0, 1, 0, 14, 1, 1, 0, 1),  me(1, 1, 1, 1, 16'd1), "a_branch_over_hazard"};
    tva[9]  = '{mi(1, 13, 0, 1, 0, 15, 1, 1, 1, 1),  me(1, 1, 1, 1, 16'd1), "a_flush_cycle2"};
    tva[10] = '{mi(1, 15, 14, 1, 1, 16, 1, 0, 0, 0), me(0, 1, 1, 0, 16'd1), "a_after_flush"};
    tva[11] = '{mi(1, 0, 0, 0, 0, 0, 0, 0, 1, 0),    me(0, 1, 1, 1, 16'd1), "a_jump"};
    tva[12] = '{mi(1, 0, 0, 0, 0, 20, 1, 1, 0, 0),   me(0, 1, 1, 0, 16'd1), "a_lw20"};
    tva[13] = '{mi(1, 20, 0, 1, 0, 0, 0, 0, 1, 0),   me(1, 0, 0, 0, 16'd1), "a_jump_stalled"};
    tva[14] = '{mi(1, 20, 0, 1, 0, 0, 0, 0, 1, 0),   me(0, 1, 1, 1, 16'd2), "a_jump_retry"};
    tva[15] = '{mi(1, 0, 0, 0, 0, 21, 1, 1, 0, 0),   me(0, 1, 1, 0, 16'd2), "a_lw21"};
    tva[16] = '{mi(0, 21, 0, 1, 0, 0, 0, 0, 0, 0),   me(0, 1, 1, 0, 16'd2), "a_invalid_no_hazard"};

    // no-forwarding instance: EX and MEM matches stall, counter saturates at 3
    tvb[0] = '{mi(1, 0, 0, 0, 0, 9, 1, 0, 0, 0),     me(0, 1, 1, 0, 16'd0), "b_add9"};
    tvb[1] = '{mi(1, 0, 9, 0, 1, 3, 1, 0, 0, 0),     me(1, 0, 0, 0, 16'd0), "b_raw_ex"};
    tvb[2] = '{mi(1, 0, 9, 0, 1, 3, 1, 0, 0, 0),     me(1, 0, 0, 0, 16'd1), "b_raw_mem"};
    tvb[3] = '{mi(1, 0, 9, 0, 1, 3, 1, 0, 0, 0),     me(0, 1, 1, 0, 16'd2), "b_raw_wb_issue"};
    tvb[4] = '{mi(1, 3, 0, 1, 0, 4, 1, 0, 0, 0),     me(1, 0, 0, 0, 16'd2), "b_stall3"};
    tvb[5] = '{mi(1, 3, 0, 1, 0, 4, 1, 0, 0, 0),     me(1, 0, 0, 0, 16'd3), "b_stall_sat"};
    tvb[6] = '{mi(1, 3, 0, 1, 0, 4, 1, 0, 0, 0),     me(0, 1, 1, 0, 16'd3), "b_no_wrap"};
    tvb[7] = '{mi(1, 4, 0, 1, 0, 5, 1, 0, 0, 1),     me(1, 1, 1, 1, 16'd3), "b_branch_pen1"};
    tvb[8] = '{mi(1, 5, 4, 1, 0, 6, 0, 0, 0, 0),     me(0, 1, 1, 0, 16'd3), "b_flushed_absent"};
    tvb[9] = '{mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),     me(0, 1, 1, 0, 16'd3), "b_idle"};

    // reset values, with inputs that would otherwise issue
    a = mi(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
    b = a;
    #3;
    push(1'b0, me(1, 0, 0, 0, 16'd0), "a_reset");
    push(1'b1, me(1, 0, 0, 0, 16'd0), "b_reset");
    pop_check();
    pop_check();
    a = idle;
    b = idle;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) run_vec(1'b0, tva[i].i, tva[i].e, tva[i].nm);
    for (int i = 0; i < 10; i++) run_vec(1'b1, tvb[i].i, tvb[i].e, tvb[i].nm);

    // reset during a load-use stall clears the stale EX entry
    run_vec(1'b0, mi(1, 0, 0, 0, 0, 22, 1, 1, 0, 0), me(0, 1, 1, 0, 16'd2), "h_lw22");
    @(posedge clk);
    #1;
    a = mi(1, 22, 0, 1, 0, 0, 0, 0, 0, 0);
    push(1'b0, me(1, 0, 0, 0, 16'd2), "h_stall_before_rst");
    #1 pop_check();
    #1 rst = 1'b1;
    push(1'b0, me(1, 0, 0, 0, 16'd0), "h_rst_mid_stall");
    #1 pop_check();
    #1 rst = 1'b0;
    push(1'b0, me(0, 1, 1, 0, 16'd0), "h_stale_no_stall");
    @(negedge clk);
    pop_check();

    // reset during the flush window returns to RUN
    run_vec(1'b0, mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), me(1, 1, 1, 1, 16'd0), "h_branch");
    @(posedge clk);
    #1;
    a = idle;
    push(1'b0, me(1, 1, 1, 1, 16'd0), "h_in_flush");
    #1 pop_check();
    #1 rst = 1'b1;
    push(1'b0, me(1, 0, 0, 0, 16'd0), "h_rst_mid_flush");
    #1 pop_check();
    #1 rst = 1'b0;
    push(1'b0, me(0, 1, 1, 0, 16'd0), "h_run_after_rst");
    @(negedge clk);
    pop_check();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
